// File: rtl/dds_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// dds_cfg_sequencer
//
// Front-panel control sequencer for the DDS/PWM datapath. Raw keys and entry
// switches are synchronized, debounced and edge-detected. A small entry FSM
// (IDLE / ENTRY / APPLY) turns those events into the DDS configuration: tuning
// word, waveform select and PWM duty, plus a one-cycle cfg_valid strobe.
//
// Ports:
//   clk        in   1     system clock
//   rst        in   1     asynchronous, active-high reset
//   key        in   5     raw push keys, active-high
//                           [0] waveform, [1] freq up, [2] freq down,
//                           [3] step size, [4] restore defaults / abort
//   sw12       in   1     raw high-digit increment switch, active-low
//   sw34       in   1     raw low-digit increment switch, active-low
//   sw_ok      in   1     raw commit switch, active-low
//   duty_sel   in   1     commit target: 0 = frequency, 1 = duty
//   freq_word  out  FW_W  DDS tuning word
//   wave_sel   out  2     waveform select
//   duty       out  8     PWM duty, 1/256 units
//   cfg_valid  out  1     one-cycle pulse on any configuration update
//   entry_val  out  8     current entry value, for display
//   state_o    out  2     FSM state: 0 IDLE, 1 ENTRY, 2 APPLY
//
// Build option:
//   DDS_CFG_TIMEOUT_EN  when defined, an open entry that sees no digit event
//                       for TIMEOUT cycles is discarded silently.
// ---------------------------------------------------------------------------
module dds_cfg_sequencer #(
   parameter int unsigned DEB_CNT    = 16,
   parameter int unsigned FW_W       = 24,
   parameter int unsigned FW_DEF     = 4096,
   parameter int unsigned FREQ_SHIFT = 8,
   parameter int unsigned DUTY_DEF   = 128,
   parameter int unsigned TIMEOUT    = 1000000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      key,
   input  logic            sw12,
   input  logic            sw34,
   input  logic            sw_ok,
   input  logic            duty_sel,
   output logic [FW_W-1:0] freq_word,
   output logic [1:0]      wave_sel,
   output logic [7:0]      duty,
   output logic            cfg_valid,
   output logic [7:0]      entry_val,
   output logic [1:0]      state_o
);

   localparam int unsigned N_IN  = 8;
   localparam int unsigned CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

   // Bit positions in the conditioned input vector.
   localparam int unsigned IX_WAVE = 0;
   localparam int unsigned IX_UP   = 1;
   localparam int unsigned IX_DOWN = 2;
   localparam int unsigned IX_STEP = 3;
   localparam int unsigned IX_REST = 4;
   localparam int unsigned IX_SW12 = 5;
   localparam int unsigned IX_SW34 = 6;
   localparam int unsigned IX_OK   = 7;

   if (DEB_CNT < 1 || TIMEOUT < 1 || FW_W < 8) begin : g_param_check
      $error("dds_cfg_sequencer: DEB_CNT and TIMEOUT must be >= 1, FW_W >= 8");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ENTRY = 2'd1,
      ST_APPLY = 2'd2
   } state_t;

   // The single event acted on in a cycle, after priority resolution.
   typedef enum logic [3:0] {
      EV_NONE,
      EV_RESTORE,
      EV_OK,
      EV_SW12,
      EV_SW34,
      EV_WAVE,
      EV_UP,
      EV_DOWN,
      EV_STEP
   } event_t;

   // ------------------------------------------------------------------------
   // Input conditioning: invert active-low switches so every bit is
   // "1 = pressed", then synchronize, debounce and detect rising edges.
   // ------------------------------------------------------------------------
   logic [N_IN-1:0]  raw_vec;
   logic [N_IN-1:0]  sync1_q, sync2_q;
   logic [N_IN-1:0]  filt_q, filt_prev_q;
   logic [CNT_W-1:0] deb_cnt_q [N_IN];
   logic             dsel_s1_q, dsel_s2_q;
   logic [N_IN-1:0]  ev;

   assign raw_vec = {~sw_ok, ~sw34, ~sw12, key};

   always_ff @(posedge clk or posedge rst) begin : p_cond
      if (rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         filt_q      <= '0;
         filt_prev_q <= '0;
         dsel_s1_q   <= 1'b0;
         dsel_s2_q   <= 1'b0;
         // NOTE: these counters are a small register array, not a RAM, so
         // resetting them costs nothing and keeps reset release event-free.
         for (int i = 0; i < N_IN; i++) begin
            deb_cnt_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments keep the synchronizer a true
         // two-stage pipeline regardless of statement order.
         sync1_q     <= raw_vec;
         sync2_q     <= sync1_q;
         filt_prev_q <= filt_q;
         dsel_s1_q   <= duty_sel;
         dsel_s2_q   <= dsel_s1_q;
         // The counter tracks consecutive samples that disagree with the
         // filtered level; any agreeing sample restarts it.
         for (int i = 0; i < N_IN; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
               deb_cnt_q[i] <= '0;
            end else if (deb_cnt_q[i] == CNT_W'(DEB_CNT - 1)) begin
               filt_q[i]    <= sync2_q[i];
               deb_cnt_q[i] <= '0;
            end else begin
               deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign ev = filt_q & ~filt_prev_q;

   // ------------------------------------------------------------------------
   // Priority resolution and datapath helpers.
   // ------------------------------------------------------------------------
   state_t          state_q;
   logic [FW_W-1:0] freq_q;
   logic [1:0]      wave_q;
   logic [7:0]      duty_q;
   logic [1:0]      step_idx_q;
   logic [7:0]      entry_q;
   logic            cfg_valid_q;

   event_t          ev_sel;
   logic [FW_W-1:0] step;
   logic [FW_W:0]   freq_sum;
   logic [FW_W-1:0] freq_inc, freq_dec, freq_commit;

   always_comb begin : p_prio
      // NOTE: ev_sel gets a default before the chain so no path leaves it
      // unassigned and no latch is inferred.
      ev_sel = EV_NONE;
      if      (ev[IX_REST]) ev_sel = EV_RESTORE;
      else if (ev[IX_OK])   ev_sel = EV_OK;
      else if (ev[IX_SW12]) ev_sel = EV_SW12;
      else if (ev[IX_SW34]) ev_sel = EV_SW34;
      else if (ev[IX_WAVE]) ev_sel = EV_WAVE;
      else if (ev[IX_UP])   ev_sel = EV_UP;
      else if (ev[IX_DOWN]) ev_sel = EV_DOWN;
      else if (ev[IX_STEP]) ev_sel = EV_STEP;
   end

   always_comb begin : p_arith
      step        = {{(FW_W-1){1'b0}}, 1'b1} << {step_idx_q, 2'b00};
      freq_sum    = {1'b0, freq_q} + {1'b0, step};
      freq_inc    = freq_sum[FW_W] ? {FW_W{1'b1}} : freq_sum[FW_W-1:0];
      freq_dec    = (freq_q < step) ? '0 : (freq_q - step);
      freq_commit = FW_W'(entry_q) << FREQ_SHIFT;
   end

`ifdef DDS_CFG_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] to_cnt_q;
`endif

   // ------------------------------------------------------------------------
   // Entry FSM with registered configuration outputs.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin : p_fsm
      if (rst) begin
         state_q     <= ST_IDLE;
         freq_q      <= FW_W'(FW_DEF);
         wave_q      <= 2'd0;
         duty_q      <= 8'(DUTY_DEF);
         step_idx_q  <= 2'd0;
         entry_q     <= 8'd0;
         cfg_valid_q <= 1'b0;
`ifdef DDS_CFG_TIMEOUT_EN
         to_cnt_q    <= '0;
`endif
      end else begin
         cfg_valid_q <= 1'b0;
         // Restore wins from IDLE and ENTRY; APPLY is a fixed single cycle
         // and drops every event.
         if (ev_sel == EV_RESTORE && state_q != ST_APPLY) begin
            freq_q      <= FW_W'(FW_DEF);
            wave_q      <= 2'd0;
            duty_q      <= 8'(DUTY_DEF);
            step_idx_q  <= 2'd0;
            entry_q     <= 8'd0;
            state_q     <= ST_IDLE;
            cfg_valid_q <= 1'b1;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  unique case (ev_sel)
                     EV_SW12: begin
                        entry_q[7:4] <= entry_q[7:4] + 4'd1;
                        state_q      <= ST_ENTRY;
`ifdef DDS_CFG_TIMEOUT_EN
                        to_cnt_q     <= '0;
`endif
                     end
                     EV_SW34: begin
                        entry_q[3:0] <= entry_q[3:0] + 4'd1;
                        state_q      <= ST_ENTRY;
`ifdef DDS_CFG_TIMEOUT_EN
                        to_cnt_q     <= '0;
`endif
                     end
                     EV_WAVE: begin
                        wave_q      <= wave_q + 2'd1;
                        cfg_valid_q <= 1'b1;
                     end
                     EV_UP: begin
                        freq_q      <= freq_inc;
                        cfg_valid_q <= 1'b1;
                     end
                     EV_DOWN: begin
                        freq_q      <= freq_dec;
                        cfg_valid_q <= 1'b1;
                     end
                     EV_STEP: begin
                        step_idx_q <= step_idx_q + 2'd1;
                     end
                     default: ;
                  endcase
               end
               ST_ENTRY: begin
                  unique case (ev_sel)
                     EV_OK: state_q <= ST_APPLY;
                     EV_SW12: begin
                        entry_q[7:4] <= entry_q[7:4] + 4'd1;
`ifdef DDS_CFG_TIMEOUT_EN
                        to_cnt_q     <= '0;
`endif
                     end
                     EV_SW34: begin
                        entry_q[3:0] <= entry_q[3:0] + 4'd1;
`ifdef DDS_CFG_TIMEOUT_EN
                        to_cnt_q     <= '0;
`endif
                     end
                     default: begin
`ifdef DDS_CFG_TIMEOUT_EN
                        // Abandoned entry: discard silently, no cfg_valid.
                        if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                           entry_q <= 8'd0;
                           state_q <= ST_IDLE;
                        end else begin
                           to_cnt_q <= to_cnt_q + 1'b1;
                        end
`endif
                     end
                  endcase
               end
               ST_APPLY: begin
                  if (dsel_s2_q) begin
                     duty_q <= entry_q;
                  end else begin
                     freq_q <= freq_commit;
                  end
                  entry_q     <= 8'd0;
                  state_q     <= ST_IDLE;
                  cfg_valid_q <= 1'b1;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign freq_word = freq_q;
   assign wave_sel  = wave_q;
   assign duty      = duty_q;
   assign cfg_valid = cfg_valid_q;
   assign entry_val = entry_q;
   assign state_o   = state_q;

endmodule
